regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite, WriteRegister, WriteData) between two writeback requesters: the ALU and the memory/load unit.
- Buffers each requester in a small FIFO and grants one write per cycle. Grant uses fixed priority with a starvation guard. When both FIFO heads target the same register, the older write goes first.
- Outputs are registered on posedge clk, so they are stable for the register file's negedge write.
- Also exports a busy mask of pending destination registers for the hazard/stall logic.

---
 rtl/regfile_arb_pkg.sv | 33 +++
 rtl/regfile_write_arbiter_fifo.sv | 71 +++++++
 rtl/regfile_write_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared widths, writeback entry layout and age/one-hot helpers for the
// register-file write arbiter.
package regfile_arb_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned NREGS  = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } wb_entry_t;

  // a is older than b when b is ahead of a by less than half the tag space
  function automatic logic tag_older(input logic [TAG_W-1:0] a,
                                     input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] d;
    d = b - a;
    return (d != '0) && !d[TAG_W-1];
  endfunction

  function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_W-1:0] r);
    logic [NREGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// Small circular FIFO of writeback entries; also reports the set of
// destination registers held by its valid entries.
module wb_fifo
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  wb_entry_t        i_entry,
  input  logic             i_pop,
  output wb_entry_t        o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [NREGS-1:0] o_busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + 1'b1;
        r_vld[r_rd_ptr] <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: r_vld gates every use of it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

  always_comb begin
    o_busy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) o_busy = o_busy | reg_onehot(r_mem[i].rd);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write
// port: per-requester FIFOs, age ordering on same-register heads, starvation guard.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [NREGS-1:0]  busy_mask
);

  localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [TAG_W-1:0]    r_tag;
  logic [STARVE_W-1:0] r_starve;
  logic                r_regwrite;
  logic [ADDR_W-1:0]   r_wreg;
  logic [DATA_W-1:0]   r_wdata;

  logic             w_alu_full, w_alu_empty, w_mem_full, w_mem_empty;
  logic             w_alu_push, w_mem_push;
  logic             w_alu_win, w_mem_win;
  logic [TAG_W-1:0] w_alu_tag;
  wb_entry_t        w_alu_in, w_mem_in, w_alu_head, w_mem_head;
  logic [NREGS-1:0] w_alu_busy, w_mem_busy;

  assign alu_ready = reset && !w_alu_full;
  assign mem_ready = reset && !w_mem_full;

  // Register 31 completes the handshake but is never queued or tagged.
  assign w_alu_push = alu_valid && alu_ready && (alu_reg != ZERO_REG);
  assign w_mem_push = mem_valid && mem_ready && (mem_reg != ZERO_REG);

  // Mem takes the lower tag on a same-cycle accept, so it counts as older.
  assign w_alu_tag = r_tag + TAG_W'(w_mem_push);
  assign w_mem_in  = '{rd: mem_reg, data: mem_data, tag: r_tag};
  assign w_alu_in  = '{rd: alu_reg, data: alu_data, tag: w_alu_tag};

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_alu_push),
    .i_entry (w_alu_in),
    .i_pop   (w_alu_win),
    .o_head  (w_alu_head),
    .o_full  (w_alu_full),
    .o_empty (w_alu_empty),
    .o_busy  (w_alu_busy)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_mem_push),
    .i_entry (w_mem_in),
    .i_pop   (w_mem_win),
    .o_head  (w_mem_head),
    .o_full  (w_mem_full),
    .o_empty (w_mem_empty),
    .o_busy  (w_mem_busy)
  );

  always_comb begin
    w_alu_win = 1'b0;
    w_mem_win = 1'b0;
    if (!w_alu_empty && !w_mem_empty) begin
      if (w_alu_head.rd == w_mem_head.rd)
        w_mem_win = tag_older(w_mem_head.tag, w_alu_head.tag);
      else
        w_mem_win = (r_starve == STARVE_W'(STARVE_MAX));
      w_alu_win = !w_mem_win;
    end else if (!w_alu_empty) begin
      w_alu_win = 1'b1;
    end else if (!w_mem_empty) begin
      w_mem_win = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag      <= '0;
      r_starve   <= '0;
      r_regwrite <= 1'b0;
      r_wreg     <= ZERO_REG;
      r_wdata    <= '0;
    end else begin
      r_tag <= r_tag + TAG_W'(w_mem_push) + TAG_W'(w_alu_push);

      if (w_mem_empty || w_mem_win)
        r_starve <= '0;
      else if (w_alu_win && (r_starve != STARVE_W'(STARVE_MAX)))
        r_starve <= r_starve + 1'b1;

      r_regwrite <= w_alu_win || w_mem_win;
      if (w_mem_win) begin
        r_wreg  <= w_mem_head.rd;
        r_wdata <= w_mem_head.data;
      end else if (w_alu_win) begin
        r_wreg  <= w_alu_head.rd;
        r_wdata <= w_alu_head.data;
      end
    end
  end

  assign RegWrite      = r_regwrite;
  assign WriteRegister = r_wreg;
  assign WriteData     = r_wdata;
  assign busy_mask     = w_alu_busy | w_mem_busy |
                         (r_regwrite ? reg_onehot(r_wreg) : '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table for single, paired
// and zero-register writes, plus hand sequences for starvation and mid-run reset.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_reg, mem_reg;
  logic [63:0] alu_data, mem_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [31:0] busy_mask;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [63:0] rf [32];

  regfile_write_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_reg       (alu_reg),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_reg       (mem_reg),
    .mem_data      (mem_data),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .busy_mask     (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: writes on the falling edge.
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(negedge clk) if (RegWrite) rf[WriteRegister] <= WriteData;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [63:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [63:0] md;
    logic        rw;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic [31:0] busy;
  } vec_t;

  vec_t tv [11];

  function automatic vec_t mk(logic av, logic [4:0] ar, logic [63:0] ad,
                              logic mv, logic [4:0] mr, logic [63:0] md,
                              logic rw, logic [4:0] wr, logic [63:0] wd,
                              logic [31:0] busy);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad;
    v.mv = mv; v.mr = mr; v.md = md;
    v.rw = rw; v.wr = wr; v.wd = wd; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [63:0] md);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);

    // Inputs applied after posedge k; outputs checked at the following negedge
    // reflect everything accepted up to posedge k.
    tv[0]  = mk(1, 5'd5,  64'hAAAA, 0, 5'd0, 64'h0,  0, 5'd31, 64'h0,    32'h0);
    tv[1]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  0, 5'd31, 64'h0,    32'h20);
    tv[2]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 5'd5,  64'hAAAA, 32'h20);
    tv[3]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  0, 5'd5,  64'hAAAA, 32'h0);
    tv[4]  = mk(1, 5'd3,  64'h22,   1, 5'd3, 64'h11, 0, 5'd5,  64'hAAAA, 32'h0);
    tv[5]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  0, 5'd5,  64'hAAAA, 32'h8);
    tv[6]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 5'd3,  64'h11,   32'h8);
    tv[7]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 5'd3,  64'h22,   32'h8);
    tv[8]  = mk(1, 5'd31, 64'hFFFF, 0, 5'd0, 64'h0,  0, 5'd3,  64'h22,   32'h0);
    tv[9]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  0, 5'd3,  64'h22,   32'h0);
    tv[10] = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  0, 5'd3,  64'h22,   32'h0);

    @(negedge clk);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_wreg", WriteRegister, 31);
    chk("rst_wdata", WriteData, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    #2 reset = 1'b1;

    for (int k = 0; k < 11; k++) begin
      @(posedge clk);
      #1 drive(tv[k].av, tv[k].ar, tv[k].ad, tv[k].mv, tv[k].mr, tv[k].md);
      @(negedge clk);
      chk($sformatf("v%0d_regwrite", k), RegWrite, tv[k].rw);
      chk($sformatf("v%0d_wreg", k), WriteRegister, tv[k].wr);
      chk($sformatf("v%0d_wdata", k), WriteData, tv[k].wd);
      chk($sformatf("v%0d_busy", k), busy_mask, tv[k].busy);
      chk($sformatf("v%0d_alu_ready", k), alu_ready, 1);
      chk($sformatf("v%0d_mem_ready", k), mem_ready, 1);
    end

    chk("rf_r5", rf[5], 64'hAAAA);
    chk("rf_r3_age_order", rf[3], 64'h22);
    chk("rf_r31_untouched", rf[31], 64'h0);

    // Both requesters streaming to different registers.
    @(posedge clk);
    #1 drive(1'b1, 5'd8, 64'h8888, 1'b1, 5'd7, 64'h7777);
    @(posedge clk);
    @(negedge clk);
    chk("stream_first_regwrite", RegWrite, 0);
    chk("stream_first_busy", busy_mask, 32'h180);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("stream%0d_regwrite", k), RegWrite, 1);
      chk($sformatf("stream%0d_wreg", k), WriteRegister, (k % 4 == 3) ? 5'd7 : 5'd8);
      chk($sformatf("stream%0d_wdata", k), WriteData, (k % 4 == 3) ? 64'h7777 : 64'h8888);
      chk($sformatf("stream%0d_busy", k), busy_mask, 32'h180);
      chk($sformatf("stream%0d_mem_ready", k), mem_ready, (k % 4 == 3) ? 1 : 0);
      chk($sformatf("stream%0d_alu_ready", k), alu_ready, (k % 4 == 3) ? 0 : 1);
    end

    // Reset mid-stream with both FIFOs occupied and a write on the port.
    #2 reset = 1'b0;
    #1;
    chk("midrst_regwrite", RegWrite, 0);
    chk("midrst_wreg", WriteRegister, 31);
    chk("midrst_wdata", WriteData, 0);
    chk("midrst_busy", busy_mask, 0);
    chk("midrst_alu_ready", alu_ready, 0);
    chk("midrst_mem_ready", mem_ready, 0);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post%0d_regwrite", k), RegWrite, 0);
      chk($sformatf("post%0d_busy", k), busy_mask, 0);
      chk($sformatf("post%0d_alu_ready", k), alu_ready, 1);
      chk($sformatf("post%0d_mem_ready", k), mem_ready, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
